// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALU/LSU operation codes, exception causes,
// load/store stage FSM states and the MEM/WB register record.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
        ALU_SB, ALU_SH, ALU_SW
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        LD_MISALIGN = 4'd4,
        LD_FAULT    = 4'd5,
        ST_MISALIGN = 4'd6,
        ST_FAULT    = 4'd7
    } exc_cause_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RSP,
        LSU_HOLD
    } lsu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd_data;
        logic [4:0]  rd_addr;
        logic        rd_wr_ena;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        exc;
        logic [3:0]  exc_cause;
        logic        tb_mem_wrt;
        logic        tb_mem_read;
        logic        tb_update;
    } memwb_t;

    function automatic logic is_load(alu_ctrl_e op);
        return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
               (op == ALU_LBU) || (op == ALU_LHU);
    endfunction

    function automatic logic is_store(alu_ctrl_e op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane replication and byte enables,
// load byte/half extraction with sign/zero extension, misalignment detect.
module lsu_align
    import riscv_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  alu_ctrl_e   op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic        misal_raw;
    logic [1:0]  off;
    logic [7:0]  rbytes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        misal_raw = 1'b0;
        case (op)
            ALU_LH, ALU_LHU, ALU_SH: misal_raw = addr_lo[0];
            ALU_LW, ALU_SW:          misal_raw = |addr_lo;
            default:                 misal_raw = 1'b0;
        endcase
    end

    // Without the check, a misaligned access is issued as if it were at offset 0.
    assign misaligned = ALIGN_CHECK ? misal_raw : 1'b0;
    assign off        = (!ALIGN_CHECK && misal_raw) ? 2'b00 : addr_lo;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rbyte
            assign rbytes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rbytes[off];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        case (op)
            ALU_SB: begin
                be         = 4'b0001 << off;
                wdata_lane = {4{wdata[7:0]}};
            end
            ALU_SH: begin
                be         = 4'b0011 << {off[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            ALU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            ALU_LBU: load_data = {24'h0, byte_sel};
            ALU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            ALU_LHU: load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with a req/gnt/rvalid data-memory port, wait-state
// handling, load/store exceptions and the MEM/WB register.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR   = riscv_pkg::NOP_INSTR,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  alu_ctrl_e       op_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_wr_ena_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    input  logic            stall_wb_i,
    output logic            stall_mem_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_err_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wr_ena_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic            exc_o,
    output logic [3:0]      exc_cause_o,
    output logic            tb_mem_wrt_o,
    output logic            tb_mem_read_o,
    output logic            tb_update_o
);

    if (XLEN != 32) begin : g_xlen_check
        $error("mem_stage_lsu supports XLEN=32 only");
    end

    lsu_state_e  state_reg, state_next;
    memwb_t      wb_reg, wb_next, hold_reg, hold_next;
    memwb_t      bubble_rec, pass_rec, retire_rec;
    logic        orphan_reg, orphan_next;
    logic        op_load, op_store, misal_raw, misal, mem_go;
    logic [3:0]  be;
    logic [31:0] wdata_lane, load_data;

    lsu_align #(.ALIGN_CHECK(ALIGN_CHECK)) u_align (
        .op         (op_i),
        .addr_lo    (mem_addr_i[1:0]),
        .wdata      (mem_wdata_i),
        .rdata      (dmem_rdata_i),
        .be         (be),
        .wdata_lane (wdata_lane),
        .load_data  (load_data),
        .misaligned (misal_raw)
    );

    assign op_load  = valid_i && is_load(op_i);
    assign op_store = valid_i && is_store(op_i);
    assign misal    = (op_load || op_store) && misal_raw;
    assign mem_go   = (op_load || op_store) && !misal && !rst_i;

    always_comb begin
        bubble_rec       = '0;
        bubble_rec.pc    = pc_i;
        bubble_rec.instr = NOP_INSTR;

        pass_rec = bubble_rec;
        if (valid_i) begin
            pass_rec.instr       = instr_i;
            pass_rec.rd_data     = rd_data_i;
            pass_rec.rd_addr     = rd_addr_i;
            pass_rec.rd_wr_ena   = rd_wr_ena_i;
            pass_rec.mem_addr    = mem_addr_i;
            pass_rec.mem_data    = mem_wdata_i;
            pass_rec.tb_mem_read = op_load;
            pass_rec.tb_mem_wrt  = op_store;
            pass_rec.tb_update   = |instr_i;
            if (misal) begin
                pass_rec.rd_data   = '0;
                pass_rec.rd_wr_ena = 1'b0;
                pass_rec.exc       = 1'b1;
                pass_rec.exc_cause = op_load ? LD_MISALIGN : ST_MISALIGN;
            end
        end

        // Upstream holds its inputs during the access, so they still describe it.
        retire_rec             = pass_rec;
        retire_rec.tb_mem_read = is_load(op_i);
        retire_rec.tb_mem_wrt  = is_store(op_i);
        retire_rec.rd_data     = is_load(op_i) ? load_data : rd_data_i;
        retire_rec.rd_wr_ena   = rd_wr_ena_i && !dmem_err_i;
        retire_rec.exc         = dmem_err_i;
        retire_rec.exc_cause   = 4'd0;
        if (dmem_err_i) begin
            retire_rec.rd_data   = '0;
            retire_rec.exc_cause = is_load(op_i) ? LD_FAULT : ST_FAULT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg          <= LSU_IDLE;
            wb_reg             <= '0;
            wb_reg.pc          <= RESET_PC;
            wb_reg.instr       <= NOP_INSTR;
            hold_reg           <= '0;
            orphan_reg         <= 1'b1;
        end else begin
            state_reg  <= state_next;
            wb_reg     <= wb_next;
            hold_reg   <= hold_next;
            orphan_reg <= orphan_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LSU_IDLE: if (mem_go) state_next = dmem_gnt_i ? LSU_RSP : LSU_REQ;
            LSU_REQ:  if (dmem_gnt_i) state_next = LSU_RSP;
            LSU_RSP:  if (dmem_rvalid_i) state_next = stall_wb_i ? LSU_HOLD : LSU_IDLE;
            LSU_HOLD: if (!stall_wb_i) state_next = LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    always_comb begin
        wb_next           = wb_reg;
        wb_next.tb_update = 1'b0;
        hold_next         = hold_reg;
        dmem_req_o        = 1'b0;
        stall_mem_o       = stall_wb_i;
        case (state_reg)
            LSU_IDLE: begin
                if (mem_go) begin
                    dmem_req_o  = 1'b1;
                    stall_mem_o = 1'b1;
                    if (!stall_wb_i) wb_next = bubble_rec;
                end else if (!stall_wb_i) begin
                    wb_next = pass_rec;
                end
            end
            LSU_REQ: begin
                dmem_req_o  = 1'b1;
                stall_mem_o = 1'b1;
                if (!stall_wb_i) wb_next = bubble_rec;
            end
            LSU_RSP: begin
                if (dmem_rvalid_i) begin
                    if (!stall_wb_i) wb_next = retire_rec;
                    else             hold_next = retire_rec;
                end else begin
                    stall_mem_o = 1'b1;
                    if (!stall_wb_i) wb_next = bubble_rec;
                end
            end
            LSU_HOLD: begin
                stall_mem_o = 1'b1;
                if (!stall_wb_i) wb_next = hold_reg;
            end
            default: ;
        endcase
    end

    // A single stray response is tolerated after reset abandons an access.
    always_comb begin
        orphan_next = orphan_reg;
        if ((dmem_req_o && dmem_gnt_i) || (dmem_rvalid_i && state_reg != LSU_RSP))
            orphan_next = 1'b0;
    end

    rvalid_outside_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        (dmem_rvalid_i && (state_reg == LSU_IDLE || state_reg == LSU_REQ)) |-> orphan_reg);

    assign dmem_we_o    = dmem_req_o && is_store(op_i);
    assign dmem_addr_o  = dmem_req_o ? {mem_addr_i[XLEN-1:2], 2'b00} : '0;
    assign dmem_be_o    = dmem_req_o ? be : 4'b0000;
    assign dmem_wdata_o = dmem_req_o ? wdata_lane : '0;

    assign pc_o          = wb_reg.pc;
    assign instr_o       = wb_reg.instr;
    assign rd_data_o     = wb_reg.rd_data;
    assign rd_addr_o     = wb_reg.rd_addr;
    assign rd_wr_ena_o   = wb_reg.rd_wr_ena;
    assign mem_addr_o    = wb_reg.mem_addr;
    assign mem_data_o    = wb_reg.mem_data;
    assign exc_o         = wb_reg.exc;
    assign exc_cause_o   = wb_reg.exc_cause;
    assign tb_mem_wrt_o  = wb_reg.tb_mem_wrt;
    assign tb_mem_read_o = wb_reg.tb_mem_read;
    assign tb_update_o   = wb_reg.tb_update;

endmodule
